// File: rtl/md5_search_ctrl.sv
// Search controller: hands nonces from [nonce_base, nonce_limit] to NUM_CH md5 cores and
// reports the first digest-prefix match or range exhaustion. Optional: MD5_SEARCH_CYCLE_CNT_EN.
module md5_search_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int NONCE_W    = 32,
    parameter int MATCH_BITS = 24,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      stop,
    input  logic [NONCE_W-1:0]        nonce_base,
    input  logic [NONCE_W-1:0]        nonce_limit,
    input  logic [127:0]              target,
    output logic [NUM_CH-1:0]         core_start,
    output logic [NUM_CH*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CH-1:0]         core_done,
    input  logic [NUM_CH*128-1:0]     core_digest,
    output logic                      busy,
    output logic                      found,
    output logic [NONCE_W-1:0]        found_nonce,
    output logic                      exhausted,
    output logic [CNT_W-1:0]          hash_count,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NONCE_W:0]      next_q, next_d;
    logic [NONCE_W-1:0]    limit_q, limit_d;
    logic [MATCH_BITS-1:0] tgt_q, tgt_d;
    logic [NUM_CH-1:0]     chbusy_q, chbusy_d;
    logic [NONCE_W-1:0]    nonce_q [NUM_CH];
    logic [NONCE_W-1:0]    nonce_d [NUM_CH];
    logic                  found_q, found_d;
    logic                  exh_q, exh_d;
    logic                  abort_q, abort_d;
    logic                  armed_q, armed_d;
    logic                  busy_q, busy_d;
    logic [NONCE_W-1:0]    fnonce_q, fnonce_d;
    logic [CNT_W-1:0]      hcnt_q, hcnt_d;

    logic [NUM_CH-1:0]     accept_s;
    logic [NUM_CH-1:0]     match_vec_s;
    logic [NUM_CH-1:0]     core_start_s;
    logic [IDX_W-1:0]      match_idx_s;
    logic [IDX_W-1:0]      free_idx_s;
    logic [PC_W-1:0]       popcnt_s;
    logic [CNT_W:0]        hsum_s;
    logic                  have_free_s;
    logic                  any_match_s;
    logic                  active_s;
    logic                  hit_s;
    logic                  range_left_s;
    logic                  accept_run_s;
    logic                  dispatch_s;

    // Accepted completions, prefix compare and lowest-index priority selection.
    always_comb begin
        accept_s    = core_done & chbusy_q;
        match_vec_s = '0;
        match_idx_s = '0;
        free_idx_s  = '0;
        popcnt_s    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            match_vec_s[i] = accept_s[i] &&
                             (core_digest[i*128+127 -: MATCH_BITS] == tgt_q);
            match_idx_s    = match_vec_s[i] ? IDX_W'(i) : match_idx_s;
            free_idx_s     = chbusy_q[i] ? free_idx_s : IDX_W'(i);
            popcnt_s       = popcnt_s + PC_W'(accept_s[i]);
        end
        have_free_s = ~&chbusy_q;
        any_match_s = |match_vec_s;
    end

    assign active_s     = (state_q == S_RUN) || (state_q == S_DRAIN);
    // Matches count only while nothing is found and the search has not been aborted.
    assign hit_s        = active_s && !found_q && !abort_q && !stop && any_match_s;
    assign range_left_s = (next_q <= {1'b0, limit_q});
    assign accept_run_s = (state_q == S_IDLE) && run && armed_q;
    assign dispatch_s   = (state_q == S_RUN) && !stop && !hit_s && range_left_s && have_free_s;
    assign hsum_s       = {1'b0, hcnt_q} + (CNT_W + 1)'(popcnt_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_run_s) begin
                    state_d = (nonce_limit < nonce_base) ? S_FINISH : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop || hit_s || !range_left_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (chbusy_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start pulse to the lowest free channel.
    always_comb begin
        core_start_s = '0;
        if (dispatch_s) begin
            core_start_s[free_idx_s] = 1'b1;
        end else begin
            core_start_s = '0;
        end
    end

    assign core_start = core_start_s;

    // Datapath next-state: latching, busy bits, counters and result flags.
    always_comb begin
        next_d   = next_q;
        limit_d  = limit_q;
        tgt_d    = tgt_q;
        found_d  = found_q;
        exh_d    = exh_q;
        abort_d  = abort_q;
        armed_d  = armed_q;
        fnonce_d = fnonce_q;
        chbusy_d = (chbusy_q & ~accept_s) | core_start_s;
        hcnt_d   = hsum_s[CNT_W] ? {CNT_W{1'b1}} : hsum_s[CNT_W-1:0];
        if (hit_s) begin
            found_d  = 1'b1;
            fnonce_d = nonce_q[match_idx_s];
        end else begin
            found_d  = found_q;
        end
        if (dispatch_s) begin
            next_d = next_q + (NONCE_W + 1)'(1);
        end else begin
            next_d = next_q;
        end
        if (active_s && stop) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end
        if (state_q == S_IDLE && !run) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        if (accept_run_s) begin
            armed_d  = 1'b0;
            next_d   = {1'b0, nonce_base};
            limit_d  = nonce_limit;
            tgt_d    = target[127 -: MATCH_BITS];
            found_d  = 1'b0;
            abort_d  = 1'b0;
            fnonce_d = '0;
            hcnt_d   = '0;
            exh_d    = (nonce_limit < nonce_base);
        end else if (state_q == S_DRAIN && state_d == S_FINISH) begin
            exh_d = !found_d && !abort_d;
        end else begin
            exh_d = exh_q;
        end
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        // Free channels pre-load the next nonce so core_nonce is ready with core_start.
        for (int i = 0; i < NUM_CH; i++) begin
            nonce_d[i] = chbusy_d[i] ? nonce_q[i] : next_d[NONCE_W-1:0];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_q   <= '0;
            limit_q  <= '0;
            tgt_q    <= '0;
            chbusy_q <= '0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            abort_q  <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            fnonce_q <= '0;
            hcnt_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                nonce_q[i] <= '0;
            end
        end else begin
            next_q   <= next_d;
            limit_q  <= limit_d;
            tgt_q    <= tgt_d;
            chbusy_q <= chbusy_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            abort_q  <= abort_d;
            armed_q  <= armed_d;
            busy_q   <= busy_d;
            fnonce_q <= fnonce_d;
            hcnt_q   <= hcnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                nonce_q[i] <= nonce_d[i];
            end
        end
    end

    // Flatten per-channel nonces onto the output bus.
    always_comb begin
        core_nonce = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            core_nonce[i*NONCE_W +: NONCE_W] = nonce_q[i];
        end
    end

    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = fnonce_q;
    assign exhausted   = exh_q;
    assign hash_count  = hcnt_q;

`ifdef MD5_SEARCH_CYCLE_CNT_EN
    logic [CNT_W-1:0] ccnt_q, ccnt_d;

    // Busy-cycle counter next value, saturating.
    always_comb begin
        if (accept_run_s) begin
            ccnt_d = '0;
        end else if (busy_q && (ccnt_q != {CNT_W{1'b1}})) begin
            ccnt_d = ccnt_q + CNT_W'(1);
        end else begin
            ccnt_d = ccnt_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccnt_q <= '0;
        end else begin
            ccnt_q <= ccnt_d;
        end
    end

    assign cycle_count = ccnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule
